// File: rtl/fb_mem_arbiter.sv
// Frame-buffer RAM arbiter: VGA reads win by default, coprocessor fills free slots,
// a starvation counter forces a CP slot and parks the displaced VGA read for later.
module fb_mem_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              VGA_REQ,
    input  logic [ADDR_W-1:0] VGA_ADDR,
    output logic [DATA_W-1:0] VGA_RDATA,
    output logic              VGA_RVALID,
    output logic              VGA_OVERRUN,
    input  logic              CLR_OVERRUN,
    input  logic              CP_REQ,
    input  logic              CP_WE,
    input  logic [ADDR_W-1:0] CP_ADDR,
    input  logic [DATA_W-1:0] CP_WDATA,
    output logic              CP_GNT,
    output logic [DATA_W-1:0] CP_RDATA,
    output logic              CP_RVALID,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        SLOT_IDLE,
        SLOT_FORCE_CP,
        SLOT_PEND_VGA,
        SLOT_VGA,
        SLOT_CP
    } slot_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CP
    } owner_e;

    slot_e             slot;
    owner_e            issue_own;
    owner_e            own1_q, own1_d, own2_q, own2_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cp_rdata_q, cp_rdata_d;

    always_comb begin
        slot = SLOT_IDLE;
        if (CP_REQ && wait_cnt_q == LIM) slot = SLOT_FORCE_CP;
        else if (pend_v_q)               slot = SLOT_PEND_VGA;
        else if (VGA_REQ)                slot = SLOT_VGA;
        else if (CP_REQ)                 slot = SLOT_CP;
    end

    // RAM-facing outputs are held quiet while reset is asserted.
    always_comb begin
        CP_GNT    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_WE    = 1'b0;
        issue_own = OWN_NONE;
        if (RST_N) begin
            case (slot)
                SLOT_FORCE_CP, SLOT_CP: begin
                    CP_GNT    = 1'b1;
                    MEM_ADDR  = CP_ADDR;
                    MEM_WDATA = CP_WDATA;
                    MEM_WE    = CP_WE;
                    issue_own = CP_WE ? OWN_NONE : OWN_CP;
                end
                SLOT_PEND_VGA: begin
                    MEM_ADDR  = pend_addr_q;
                    issue_own = OWN_VGA;
                end
                SLOT_VGA: begin
                    MEM_ADDR  = VGA_ADDR;
                    issue_own = OWN_VGA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        ovr_d       = CLR_OVERRUN ? 1'b0 : ovr_q;
        case (slot)
            SLOT_FORCE_CP: begin
                if (VGA_REQ) begin
                    if (!pend_v_q) begin
                        pend_v_d    = 1'b1;
                        pend_addr_d = VGA_ADDR;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            SLOT_PEND_VGA: begin
                if (VGA_REQ) pend_addr_d = VGA_ADDR;
                else         pend_v_d    = 1'b0;
            end
            default: ;
        endcase

        if (!CP_REQ || CP_GNT)   wait_cnt_d = '0;
        else if (wait_cnt_q != LIM) wait_cnt_d = wait_cnt_q + CW'(1);
        else                     wait_cnt_d = wait_cnt_q;

        // Stage 1 tags the cycle MEM_RDATA is live; stage 2 drives RVALID.
        own1_d      = issue_own;
        own2_d      = own1_q;
        vga_rdata_d = (own1_q == OWN_VGA) ? MEM_RDATA : vga_rdata_q;
        cp_rdata_d  = (own1_q == OWN_CP)  ? MEM_RDATA : cp_rdata_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            wait_cnt_q  <= '0;
            ovr_q       <= 1'b0;
            own1_q      <= OWN_NONE;
            own2_q      <= OWN_NONE;
            vga_rdata_q <= '0;
            cp_rdata_q  <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            ovr_q       <= ovr_d;
            own1_q      <= own1_d;
            own2_q      <= own2_d;
            vga_rdata_q <= vga_rdata_d;
            cp_rdata_q  <= cp_rdata_d;
        end
    end

    assign VGA_RDATA   = vga_rdata_q;
    assign VGA_RVALID  = (own2_q == OWN_VGA);
    assign VGA_OVERRUN = ovr_q;
    assign CP_RDATA    = cp_rdata_q;
    assign CP_RVALID   = (own2_q == OWN_CP);

endmodule
